// File: rtl/parallel_bus_pollable_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parallel_bus_pkg
// Description : Shared FSM state encoding and bus field values for the
//               parallel-bus pollable memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
package parallel_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRIVE = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic c_DIR_WRITE = 1'b0;
    localparam logic c_DIR_READ  = 1'b1;
    localparam logic c_SEL_ADDR  = 1'b0;
    localparam logic c_SEL_DATA  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/parallel_bus_pollable_memory_ram_sync_read.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_read
// Description : Single-clock RAM, one write port and one registered read
//               port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_read #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/parallel_bus_pollable_memory.sv
`default_nettype none
// ============================================================================
// Module      : parallel_bus_pollable_memory
// Description : Slave on an asynchronous four-phase parallel bus exposing an
//               address register and a word-addressed memory.
//               Optional: PARALLEL_BUS_AUTO_INCREMENT_EN advances the address
//               after every data write and data read.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_bus_pollable_memory
    import parallel_bus_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  read,
    input  logic                  register_select,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic                  bus_oe,
    output logic                  ack,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] address
);

    // Extra constant-1 lane marks when the synchronizer has refilled after reset.
    localparam int c_SYNC_W = BUS_WIDTH + 4;

    logic [c_SYNC_W-1:0]                   w_async;
    logic [SYNC_STAGES-1:0][c_SYNC_W-1:0]  r_sync;
    logic                                  w_sync_ok;
    logic                                  w_se;
    logic                                  w_sread;
    logic                                  w_ssel;
    logic [BUS_WIDTH-1:0]                  w_sdata;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_armed;
    logic                  r_sel_q;
    logic [BUS_WIDTH-1:0]  r_data_q;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]  r_bus_out;
    logic                  r_valid;
    logic                  r_bus_oe;

    logic                  w_start;
    logic                  w_mem_we;
    logic                  w_addr_we;
    logic                  w_load_out;
    logic                  w_clear_out;
    logic                  w_ack;
    logic [BUS_WIDTH-1:0]  w_ram_rdata;
    logic [BUS_WIDTH-1:0]  w_addr_ext;

    assign w_async = {1'b1, enable, read, register_select, bus_in};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= w_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_ok = r_sync[SYNC_STAGES-1][BUS_WIDTH+3];
    assign w_se      = r_sync[SYNC_STAGES-1][BUS_WIDTH+2];
    assign w_sread   = r_sync[SYNC_STAGES-1][BUS_WIDTH+1];
    assign w_ssel    = r_sync[SYNC_STAGES-1][BUS_WIDTH];
    assign w_sdata   = r_sync[SYNC_STAGES-1][BUS_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_we    = 1'b0;
        w_load_out   = 1'b0;
        w_clear_out  = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_armed is only set once se has been seen low, so a held enable never restarts.
                if (w_sync_ok && r_armed && w_se) begin
                    w_start      = 1'b1;
                    w_next_state = (w_sread == c_DIR_READ) ? ST_FETCH : ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_ack        = 1'b1;
                w_next_state = ST_HOLD;
                if (r_sel_q == c_SEL_DATA) begin
                    w_mem_we = 1'b1;
                end else begin
                    w_addr_we = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!w_se) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_load_out   = 1'b1;
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!w_se) begin
                    w_clear_out  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_ack = 1'b1;
                if (!w_se) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_addr_ext                 = '0;
        w_addr_ext[ADDR_WIDTH-1:0] = r_address;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed   <= 1'b0;
            r_sel_q   <= 1'b0;
            r_data_q  <= '0;
            r_address <= '0;
            r_bus_out <= '0;
            r_valid   <= 1'b0;
            r_bus_oe  <= 1'b0;
        end else begin
            if (w_start) begin
                r_armed  <= 1'b0;
                r_sel_q  <= w_ssel;
                r_data_q <= w_sdata;
            end else if (w_sync_ok && !w_se) begin
                r_armed <= 1'b1;
            end

            if (w_addr_we) begin
                r_address <= r_data_q[ADDR_WIDTH-1:0];
            end
`ifdef PARALLEL_BUS_AUTO_INCREMENT_EN
            else if (w_mem_we || (w_load_out && (r_sel_q == c_SEL_DATA))) begin
                r_address <= r_address + ADDR_WIDTH'(1);
            end
`endif

            if (w_load_out) begin
                r_bus_out <= (r_sel_q == c_SEL_DATA) ? w_ram_rdata : w_addr_ext;
                r_valid   <= 1'b1;
                r_bus_oe  <= 1'b1;
            end else if (w_clear_out) begin
                r_bus_out <= '0;
                r_valid   <= 1'b0;
                r_bus_oe  <= 1'b0;
            end
        end
    end

    // Gating with reset drops a write that coincides with the reset edge.
    ram_sync_read #(
        .DATA_WIDTH (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_mem_we && !reset),
        .i_waddr (r_address),
        .i_wdata (r_data_q),
        .i_raddr (r_address),
        .o_rdata (w_ram_rdata)
    );

    assign bus_out = r_bus_out;
    assign bus_oe  = r_bus_oe;
    assign valid   = r_valid;
    assign ack     = w_ack;
    assign address = r_address;

endmodule
`default_nettype wire

// File: tb/tb_parallel_bus_pollable_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_parallel_bus_pollable_memory
// Description : Directed self-checking bench for parallel_bus_pollable_memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_bus_pollable_memory;

`ifdef PARALLEL_BUS_AUTO_INCREMENT_EN
    localparam bit c_AUTO = 1'b1;
`else
    localparam bit c_AUTO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       read = 1'b0;
    logic       register_select = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       ack;
    logic       valid;
    logic [3:0] address;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    parallel_bus_pollable_memory #(
        .BUS_WIDTH   (8),
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .read            (read),
        .register_select (register_select),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .ack             (ack),
        .valid           (valid),
        .address         (address)
    );

    // Complete four-phase write; returns with the slave back in IDLE.
    task automatic do_write(input logic sel, input logic [7:0] data);
        @(posedge clock); #1;
        read = 1'b0; register_select = sel; bus_in = data; enable = 1'b1;
        repeat (4) @(posedge clock);
        #1 enable = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Raise a read strobe and return once the slave is in DRIVE.
    task automatic start_read(input logic sel);
        @(posedge clock); #1;
        read = 1'b1; register_select = sel; enable = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic end_read();
        enable = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
        n_total++; if (bus_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", bus_oe); else n_pass++;
        n_total++; if (bus_out !== 8'h00) $display("FAIL reset_bus_out: got %h expected 00", bus_out); else n_pass++;
        n_total++; if (address !== 4'h0) $display("FAIL reset_address: got %h expected 0", address); else n_pass++;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_addr_data();
        // Address write 0x13 with handshake timing checked cycle by cycle.
        @(posedge clock); #1;
        read = 1'b0; register_select = 1'b0; bus_in = 8'h13; enable = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_total++; if (ack !== 1'b0) $display("FAIL ack_at_E: got %b expected 0", ack); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_total++; if (ack !== 1'b1) $display("FAIL ack_at_E1: got %b expected 1", ack); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_total++; if (address !== 4'h3) $display("FAIL addr_write_13: got %h expected 3", address); else n_pass++;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_total++; if (ack !== 1'b1) $display("FAIL ack_hold_until_se_low: got %b expected 1", ack); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_total++; if (ack !== 1'b0) $display("FAIL ack_fall: got %b expected 0", ack); else n_pass++;
        repeat (2) @(posedge clock);

        do_write(1'b1, 8'hA5);
        n_total++;
        if (address !== (c_AUTO ? 4'h4 : 4'h3)) $display("FAIL addr_after_data_write: got %h expected %h", address, c_AUTO ? 4'h4 : 4'h3);
        else n_pass++;
        do_write(1'b0, 8'h03);

        // Data read: valid must appear exactly at E+2.
        @(posedge clock); #1;
        read = 1'b1; register_select = 1'b1; enable = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_total++; if (valid !== 1'b0) $display("FAIL valid_at_E1: got %b expected 0", valid); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_total++; if (valid !== 1'b1) $display("FAIL valid_at_E2: got %b expected 1", valid); else n_pass++;
        n_total++; if (bus_oe !== 1'b1) $display("FAIL oe_at_E2: got %b expected 1", bus_oe); else n_pass++;
        n_total++; if (bus_out !== 8'hA5) $display("FAIL read_mem3: got %h expected a5", bus_out); else n_pass++;
        end_read();
    endtask

    task automatic test_addr_read();
        do_write(1'b0, 8'h07);
        start_read(1'b0);
        n_total++; if (bus_out !== 8'h07) $display("FAIL read_addr_reg: got %h expected 07", bus_out); else n_pass++;
        repeat (5) @(posedge clock);
        @(negedge clock);
        n_total++; if (valid !== 1'b1 || bus_oe !== 1'b1) $display("FAIL drive_hold: got valid=%b oe=%b expected 1/1", valid, bus_oe); else n_pass++;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_total++; if (valid !== 1'b1) $display("FAIL valid_before_se_low: got %b expected 1", valid); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_total++;
        if (valid !== 1'b0 || bus_oe !== 1'b0 || bus_out !== 8'h00)
            $display("FAIL drive_release: got valid=%b oe=%b out=%h expected 0/0/00", valid, bus_oe, bus_out);
        else n_pass++;
        n_total++; if (address !== 4'h7) $display("FAIL addr_after_reg_read: got %h expected 7", address); else n_pass++;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_wrap();
        do_write(1'b0, 8'h00);
        do_write(1'b1, 8'h5A);
        do_write(1'b0, 8'h0F);
        do_write(1'b1, 8'h11);
        do_write(1'b1, 8'h22);
        n_total++;
        if (address !== (c_AUTO ? 4'h1 : 4'hF)) $display("FAIL wrap_address: got %h expected %h", address, c_AUTO ? 4'h1 : 4'hF);
        else n_pass++;
        do_write(1'b0, 8'h0F);
        start_read(1'b1);
        n_total++;
        if (bus_out !== (c_AUTO ? 8'h11 : 8'h22)) $display("FAIL wrap_mem15: got %h expected %h", bus_out, c_AUTO ? 8'h11 : 8'h22);
        else n_pass++;
        end_read();
        do_write(1'b0, 8'h00);
        start_read(1'b1);
        n_total++;
        if (bus_out !== (c_AUTO ? 8'h22 : 8'h5A)) $display("FAIL wrap_mem0: got %h expected %h", bus_out, c_AUTO ? 8'h22 : 8'h5A);
        else n_pass++;
        end_read();
    endtask

    task automatic test_held_enable();
        bit ack_dropped = 1'b0;
        bit oe_seen = 1'b0;
        do_write(1'b0, 8'h06);
        @(posedge clock); #1;
        read = 1'b0; register_select = 1'b1; bus_in = 8'h77; enable = 1'b1;
        repeat (3) @(posedge clock);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ack !== 1'b1) ack_dropped = 1'b1;
            if (bus_oe !== 1'b0) oe_seen = 1'b1;
            if (i == 5) begin
                read = 1'b1; register_select = 1'b0; bus_in = 8'hEE;
            end
        end
        n_total++; if (ack_dropped) $display("FAIL held_ack_continuous: got dropout expected steady 1"); else n_pass++;
        n_total++; if (oe_seen) $display("FAIL held_write_oe: got 1 expected 0"); else n_pass++;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_total++; if (ack !== 1'b1) $display("FAIL held_ack_before_se_low: got %b expected 1", ack); else n_pass++;
        @(posedge clock); @(negedge clock);
        n_total++; if (ack !== 1'b0) $display("FAIL held_ack_fall: got %b expected 0", ack); else n_pass++;
        n_total++;
        if (address !== (c_AUTO ? 4'h7 : 4'h6)) $display("FAIL held_single_write_addr: got %h expected %h", address, c_AUTO ? 4'h7 : 4'h6);
        else n_pass++;
        repeat (2) @(posedge clock);
        do_write(1'b0, 8'h06);
        start_read(1'b1);
        n_total++; if (bus_out !== 8'h77) $display("FAIL held_mem6: got %h expected 77", bus_out); else n_pass++;
        end_read();
    endtask

    task automatic test_abort();
        bit drive_seen = 1'b0;
        do_write(1'b0, 8'h09);
        @(posedge clock); #1;
        read = 1'b1; register_select = 1'b1; enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (valid !== 1'b0 || bus_oe !== 1'b0) drive_seen = 1'b1;
        end
        n_total++; if (drive_seen) $display("FAIL abort_no_valid: got valid/oe high expected 0"); else n_pass++;
        n_total++; if (address !== 4'h9) $display("FAIL abort_address: got %h expected 9", address); else n_pass++;
    endtask

    task automatic test_reset_in_drive();
        bit restarted = 1'b0;
        do_write(1'b0, 8'h03);
        start_read(1'b1);
        n_total++; if (valid !== 1'b1) $display("FAIL pre_reset_drive: got %b expected 1", valid); else n_pass++;
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        n_total++;
        if (valid !== 1'b0 || bus_oe !== 1'b0 || ack !== 1'b0 || bus_out !== 8'h00 || address !== 4'h0)
            $display("FAIL reset_in_drive: got v=%b oe=%b ack=%b out=%h addr=%h expected all 0", valid, bus_oe, ack, bus_out, address);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (valid !== 1'b0 || ack !== 1'b0) restarted = 1'b1;
        end
        n_total++; if (restarted) $display("FAIL held_enable_after_reset: got transaction expected none"); else n_pass++;
        enable = 1'b0;
        repeat (4) @(posedge clock);
        do_write(1'b0, 8'h03);
        start_read(1'b1);
        n_total++; if (bus_out !== 8'hA5) $display("FAIL mem_survives_reset: got %h expected a5", bus_out); else n_pass++;
        end_read();
    endtask

    initial begin
        test_reset();
        test_addr_data();
        test_addr_read();
        test_wrap();
        test_held_enable();
        test_abort();
        test_reset_in_drive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parallel_bus_pollable_memory.md
PARALLEL_BUS_POLLABLE_MEMORY -- requirements
Module: parallel_bus_pollable_memory

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter BUS_WIDTH, 8, width of bus, address register and memory word.
REQ-003 Parameter ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH words, ADDR_WIDTH <= BUS_WIDTH.
REQ-004 Parameter SYNC_STAGES, 2, flops on each asynchronous master input.
REQ-005 Ports SHALL be:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  master strobe, asynchronous, 1=active.
- read  in  1  0=write, 1=read, asynchronous.
- register_select  in  1  0=address register, 1=memory data.
- bus_in  in  BUS_WIDTH  master-driven bus value.
- bus_out  out  BUS_WIDTH  slave read data; feeds the external tristate.
- bus_oe  out  1  1=slave drives bus.
- ack  out  1  write accepted.
- valid  out  1  read data on bus_out is valid.
- address  out  ADDR_WIDTH  current address register, for LEDs/debug.

Function
REQ-006 enable, read, register_select and bus_in SHALL pass through SYNC_STAGES flops before use; all latencies below count from the cycle synchronized enable (se) is first seen high (cycle E).
REQ-007 A transaction SHALL start only on a 0->1 edge of se in IDLE; an enable held high SHALL never start a second transaction.
REQ-008 FSM states SHALL be IDLE, WRITE, FETCH, DRIVE, HOLD; IDLE->WRITE (read=0) or IDLE->FETCH (read=1) at E.
REQ-009 WRITE, register_select=0: at E+1, address <= bus_in[ADDR_WIDTH-1:0]; upper bits are ignored; go to HOLD.
REQ-010 WRITE, register_select=1: at E+1, mem[address] <= bus_in; go to HOLD.
REQ-011 ack SHALL rise at E+1, stay high through HOLD, and fall the cycle after se is seen low (four-phase handshake).
REQ-012 FETCH SHALL last one cycle for the synchronous RAM read; at E+2, bus_out <= mem[address] (register_select=1) or zero-extended address (register_select=0); valid=bus_oe=1; go to DRIVE.
REQ-013 In DRIVE, bus_out, valid and bus_oe SHALL hold until se is seen low; all three SHALL clear in the same cycle, and the FSM SHALL return to IDLE.
REQ-014 If se falls while in FETCH, the read SHALL abort: no valid, no bus_oe, no address change, return to IDLE.
REQ-015 HOLD SHALL return to IDLE the cycle after se is seen low.
REQ-016 read or register_select changing mid-transaction SHALL be ignored; the values sampled at E govern.
REQ-017 bus_oe SHALL never be high while read was 0 at E.

Reset
REQ-018 Asserting reset in any state SHALL, on the next edge, force IDLE and set ack=valid=bus_oe=0, bus_out=0, address=0 and all synchronizer flops to 0.
REQ-019 Memory contents SHALL NOT be cleared by reset; a write in progress at the reset edge SHALL NOT occur.
REQ-020 After reset deasserts, an enable already high SHALL NOT start a transaction until it has been seen low.

Configuration
REQ-021 Macro PARALLEL_BUS_AUTO_INCREMENT_EN defined: after each completed data write (REQ-010) and each completed data read (entry to DRIVE with register_select=1), address SHALL increment by 1 modulo 2**ADDR_WIDTH (15->0 at default).
REQ-022 Macro undefined: address SHALL change only through an address write or reset.

Structure
REQ-023 Package parallel_bus_pkg SHALL hold the FSM state encoding and the register_select/read value constants.
REQ-024 The memory SHALL be a sub-module ram_sync_read (one write port, one synchronous read port, same clock, no reset of contents).

Verification
REQ-025 Address write 0x13 then data write 0xA5, read with register_select=1 -> valid at E+2, bus_out=0xA5, mem[3] read; ack pulses each write.
REQ-026 Read with register_select=0 after address write 0x07 -> bus_out=0x07, valid held until enable drops, then valid=bus_oe=0 together.
REQ-027 With AUTO_INCREMENT_EN, address 0xF, write 0x11 then 0x22 -> mem[15]=0x11, mem[0]=0x22, address=1; without the macro, mem[15]=0x22, address=15.
REQ-028 enable held high 20 cycles on a write -> exactly one write, ack high until one cycle after se low.
REQ-029 enable pulsed high for one synchronized cycle on a read -> abort, valid never asserted, address unchanged.
REQ-030 reset asserted in DRIVE -> next cycle all outputs 0, IDLE; memory data previously written still readable afterward.
